// File: rtl/score_pkg.sv
// Shared types for the dino-game score keeper: FSM states and BCD digits.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        OVER
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the score: clear has priority, inc wraps 9 -> 0 with carry.
module bcd_digit
    import score_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output bcd_t value_o,
    output logic carry_o
);

    bcd_t value_q, value_d;

    assign carry_o = inc_i && (value_q == BCD_MAX_DIGIT);
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (clr_i)
            value_d = '0;
        else if (inc_i)
            value_d = carry_o ? '0 : value_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

endmodule

// File: rtl/score_keeper.sv
// Session score keeper: tick prescaler, BCD score chain, level counter,
// saturation and best-score register, driven by a three-state game FSM.
module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_POINT = 6,
    parameter int LEVEL_DIGIT     = 2,
    parameter int LEVEL_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_start_i,
    input  logic                  game_over_i,
    input  logic                  game_tick_i,
    output logic [4*DIGITS-1:0]   score_o,
    output logic [4*DIGITS-1:0]   high_score_o,
    output logic [LEVEL_W-1:0]    level_o,
    output logic                  running_o,
    output logic                  new_high_o,
    output logic                  saturated_o
);

    localparam int SW = 4 * DIGITS;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_POINT - 1);

    state_e state_q, state_d;
    logic [7:0]         pre_q, pre_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SW-1:0]      high_q, high_d;
    logic               sat_q, sat_d;
    logic               nh_q, nh_d;

    logic enter_run, tick_en, finish;
    logic point, all9;
    logic [DIGITS:0]   inc;
    logic [DIGITS-1:0] carry, nine;
    logic [SW-1:0]     score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (game_start_i) state_d = RUNNING;
            RUNNING: if (game_over_i)  state_d = OVER;
            OVER:    if (game_start_i) state_d = RUNNING;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enter_run = 1'b0;
        tick_en   = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: enter_run = game_start_i;
            RUNNING: begin
                if (game_over_i)       finish    = 1'b1;
                else if (game_start_i) enter_run = 1'b1;
                else                   tick_en   = game_tick_i;
            end
            OVER: enter_run = game_start_i;
            default: ;
        endcase
    end

    assign point = tick_en && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (enter_run)
            pre_d = '0;
        else if (tick_en)
            pre_d = point ? '0 : pre_q + 8'd1;
    end

    // Points arriving at all-9s are dropped, so the chain never overflows.
    assign inc[0] = point && !all9;
    assign all9   = &nine;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (enter_run),
            .inc_i   (inc[i]),
            .value_o (score[4*i +: 4]),
            .carry_o (carry[i])
        );
        assign inc[i+1] = carry[i];
        assign nine[i]  = (score[4*i +: 4] == BCD_MAX_DIGIT);
    end

    always_comb begin
        level_d = level_q;
        sat_d   = sat_q;
        if (enter_run) begin
            level_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc[LEVEL_DIGIT] && level_q != LEVEL_MAX)
                level_d = level_q + 1'b1;
            if ((point && all9) || inc[DIGITS])
                sat_d = 1'b1;
        end
    end

    // Nibbles are 0..9, so a plain unsigned compare orders BCD MSD first.
    always_comb begin
        high_d = high_q;
        nh_d   = nh_q;
        if (enter_run) begin
            nh_d = 1'b0;
        end else if (finish) begin
            nh_d = (score > high_q);
            if (score > high_q)
                high_d = score;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            level_q <= '0;
            high_q  <= '0;
            sat_q   <= 1'b0;
            nh_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            level_q <= level_d;
            high_q  <= high_d;
            sat_q   <= sat_d;
            nh_q    <= nh_d;
        end
    end

    assign score_o      = score;
    assign high_score_o = high_q;
    assign level_o      = level_q;
    assign running_o    = (state_q == RUNNING);
    assign new_high_o   = nh_q;
    assign saturated_o  = sat_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed game sessions push expected
// output snapshots; a negedge monitor pops and compares them.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_start, game_over, game_tick;
    logic [15:0] score, high_score;
    logic [3:0]  level;
    logic        running, new_high, saturated;

    typedef struct {
        string       nm;
        logic [15:0] sc;
        logic [15:0] hs;
        logic [3:0]  lv;
        logic        run;
        logic        nh;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    score_keeper #(
        .DIGITS(4), .TICKS_PER_POINT(6), .LEVEL_DIGIT(2), .LEVEL_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_start_i (game_start),
        .game_over_i  (game_over),
        .game_tick_i  (game_tick),
        .score_o      (score),
        .high_score_o (high_score),
        .level_o      (level),
        .running_o    (running),
        .new_high_o   (new_high),
        .saturated_o  (saturated)
    );

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (score !== e.sc || high_score !== e.hs || level !== e.lv ||
                running !== e.run || new_high !== e.nh || saturated !== e.sat) begin
                failed++;
                $display("FAIL %s: got sc=%h hs=%h lv=%0d run=%b nh=%b sat=%b, want sc=%h hs=%h lv=%0d run=%b nh=%b sat=%b",
                         e.nm, score, high_score, level, running, new_high, saturated,
                         e.sc, e.hs, e.lv, e.run, e.nh, e.sat);
            end
        end
    end

    task automatic expect_now(input string nm, input logic [15:0] sc,
                              input logic [15:0] hs, input logic [3:0] lv,
                              input logic run, input logic nh, input logic sat);
        exp_t x;
        x.nm = nm; x.sc = sc; x.hs = hs; x.lv = lv;
        x.run = run; x.nh = nh; x.sat = sat;
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic o, input logic t);
        game_start = s;
        game_over  = o;
        game_tick  = t;
        @(posedge clk);
        #1;
        game_start = 1'b0;
        game_over  = 1'b0;
        game_tick  = 1'b0;
    endtask

    task automatic ticks(input int n);
        game_tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        game_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        game_start = 1'b0;
        game_over  = 1'b0;
        game_tick  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        expect_now("reset", 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
        rst = 1'b0;

        pulse(1, 0, 0);
        expect_now("start", 16'h0000, 16'h0000, 4'd0, 1, 0, 0);
        ticks(59);
        expect_now("tick59", 16'h0009, 16'h0000, 4'd0, 1, 0, 0);
        ticks(1);
        expect_now("tick60", 16'h0010, 16'h0000, 4'd0, 1, 0, 0);

        pulse(1, 0, 0);
        expect_now("restart", 16'h0000, 16'h0000, 4'd0, 1, 0, 0);
        ticks(600);
        expect_now("p100", 16'h0100, 16'h0000, 4'd1, 1, 0, 0);
        pulse(0, 1, 0);
        expect_now("over1", 16'h0100, 16'h0100, 4'd1, 0, 1, 0);
        ticks(6);
        expect_now("over_tick", 16'h0100, 16'h0100, 4'd1, 0, 1, 0);

        pulse(1, 0, 0);
        expect_now("g2start", 16'h0000, 16'h0100, 4'd0, 1, 0, 0);
        ticks(180);
        pulse(0, 1, 0);
        expect_now("over2", 16'h0030, 16'h0100, 4'd0, 0, 0, 0);

        pulse(1, 0, 0);
        ticks(600);
        pulse(0, 1, 0);
        expect_now("over3_eq", 16'h0100, 16'h0100, 4'd1, 0, 0, 0);

        pulse(1, 0, 0);
        ticks(5);
        pulse(0, 1, 1);
        expect_now("tick_over", 16'h0000, 16'h0100, 4'd0, 0, 0, 0);

        pulse(1, 0, 0);
        ticks(12);
        pulse(1, 1, 0);
        expect_now("start_over", 16'h0002, 16'h0100, 4'd0, 0, 0, 0);

        pulse(1, 0, 0);
        ticks(60000);
        expect_now("sat", 16'h9999, 16'h0100, 4'd15, 1, 0, 1);
        pulse(0, 1, 0);
        expect_now("over_sat", 16'h9999, 16'h9999, 4'd15, 0, 1, 1);
        pulse(1, 0, 0);
        expect_now("sat_clr", 16'h0000, 16'h9999, 4'd0, 1, 0, 0);

        ticks(252);
        expect_now("s42", 16'h0042, 16'h9999, 4'd0, 1, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_now("async_rst", 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
        rst = 1'b0;

        ticks(6);
        pulse(0, 1, 0);
        expect_now("idle_tick", 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
        pulse(1, 0, 0);
        ticks(6);
        expect_now("post_rst", 16'h0001, 16'h0000, 4'd0, 1, 0, 0);

        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
